alu_4_arbiter: RTL
==================

# alu_4_arbiter

Two-channel arbiter and sequencer that shares a single combinational `ALU_4` between two requesters. Each requester presents an operation (select S2..S0, Cin) and operands A/B with a req/ack handshake. The arbiter grants round-robin, drives the ALU from registered operands, captures G/Cout, and returns the result to the granted channel with a one-cycle ready pulse. It sits between the requesting datapath blocks and the one `ALU_4` instance, which is external to it.

## Interface
Parameters: none; widths are fixed at 4 bits to match `ALU_4`.

Ports:
- `CLK`  in  1  single clock; all state updates on rising edge
- `RST`  in  1  synchronous, active-high reset
- `REQ0`, `REQ1`  in  1  request from channel 0/1
- `OP0`, `OP1`  in  4  {S2,S1,S0,Cin} for channel 0/1
- `A0`, `B0`, `A1`, `B1`  in  4  operands for channel 0/1
- `ACK0`, `ACK1`  out  1  one-cycle pulse; request accepted
- `RDY0`, `RDY1`  out  1  one-cycle pulse; result valid
- `RES0`, `RES1`  out  4  captured G for channel 0/1
- `COUT0`, `COUT1`  out  1  captured Cout for channel 0/1
- `BUSY`  out  1  high in EXEC and WB
- `S2`, `S1`, `S0`, `Cin`  out  1 each  to ALU select/carry, registered
- `A`, `B`  out  4  to ALU operands, registered
- `G`  in  4  from ALU
- `Cout`  in  1  from ALU
- `ZERO0`, `ZERO1`  out  1  present only with `ALU4_ARB_ZFLAG_EN`

## Operation
- States: IDLE, EXEC, WB. Reset state IDLE.
- IDLE: if no REQ, stay. If exactly one REQx, grant x. If both, grant the channel not granted last. The last-grant pointer resets to 1, so channel 0 wins the first contest. On grant, the following registers load on the same edge: {S2,S1,S0,Cin} ← OPx, A ← Ax, B ← Bx, grant id ← x, pointer ← x. Next state is EXEC.
- EXEC: ACKx = 1 for this cycle only. The ALU settles on the registered inputs. At the ending edge, RESx ← G and COUTx ← Cout (plus ZEROx). Next state is WB.
- WB: RDYx = 1 for this cycle only. Next state is IDLE. REQ is not sampled in WB.
- Requester rule: hold REQx, OPx, Ax, Bx stable until ACKx is seen. REQx still high in the cycle after ACK is a new request.
- The ALU drive registers and RESx/COUTx hold their values until overwritten. The non-granted channel's outputs are untouched.
- Throughput: one operation per 3 cycles. Worst-case wait for a losing requester is 3 cycles.

## Timing
- Reset values: all outputs 0, including ALU drive outputs, RES, COUT, ZERO, ACK, RDY, BUSY. Pointer = 1.
- REQx sampled high at edge E0 in IDLE → ACKx high during cycle E0..E1 (EXEC) → RDYx high during E1..E2 (WB) → IDLE after E2.
- Request-to-result latency: 2 cycles after the accepting edge.
- `G` must be combinationally valid within one cycle of the ALU inputs changing; it is sampled only at the EXEC→WB edge.
- RST high at any edge: the FSM goes to IDLE and all outputs clear. An in-flight operation is dropped, with no ACK and no RDY after reset.
- REQ changing during EXEC or WB is ignored until IDLE.
- Simultaneous REQ0 and REQ1 held continuously: grants alternate 0,1,0,1…

## Configuration
- `ALU4_ARB_ZFLAG_EN` defined: ports `ZERO0` and `ZERO1` exist. ZEROx ← (G == 4'b0000) on the same edge as RESx capture. Reset value 0; the value holds until the next capture for that channel.
- Not defined: ports and registers are absent, and all other behaviour is identical.

## Test plan
- Single request: reset, then REQ0=1, OP0=4'b0011, A0=4'hF, B0=4'h1. The bench ALU stub returns G=4'h0, Cout=1. Required: ACK0 one cycle later, RDY0 the cycle after, RES0=4'h0, COUT0=1, ZERO0=1 when the macro is defined. ACK1 and RDY1 stay 0 throughout.
- Contention: REQ0 and REQ1 asserted together and held. Required: grant order 0,1,0,1, with ACKs 3 cycles apart. S2..Cin, A, B match each channel's inputs while its ACK is high.
- Result hold: channel 1 completes with the stub returning G=4'h9. Then channel 0 runs 2 operations. Required: RES1 stays 4'h9 and COUT1 is unchanged.
- Reset mid-operation: assert RST during EXEC. Required: no RDY pulse. Next cycle all outputs are 0 and state is IDLE. With both requesting after reset, channel 0 is granted first.
- Back-to-back on one channel: REQ0 held high across ACK0. Required: a second grant to channel 0 at the first IDLE edge after WB. ACK0 pulses are 3 cycles apart and each has its own RDY0.
- Sweep: all 16 OP0 values with A0=4'hF, B0=4'h1 against the real `ALU_4`. Required: RES0/COUT0 equal the ALU's G/Cout sampled in EXEC.

Source files
------------

// File: rtl/alu_4_arbiter.sv
// Round-robin arbiter/sequencer sharing one external ALU_4 between two requesters.
// Optional zero flags (ZERO0/ZERO1) are present when ALU4_ARB_ZFLAG_EN is defined.
module alu_4_arbiter (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic [3:0] OP0,
  input  logic [3:0] OP1,
  input  logic [3:0] A0,
  input  logic [3:0] B0,
  input  logic [3:0] A1,
  input  logic [3:0] B1,
  output logic       ACK0,
  output logic       ACK1,
  output logic       RDY0,
  output logic       RDY1,
  output logic [3:0] RES0,
  output logic [3:0] RES1,
  output logic       COUT0,
  output logic       COUT1,
  output logic       BUSY,
  output logic       S2,
  output logic       S1,
  output logic       S0,
  output logic       Cin,
  output logic [3:0] A,
  output logic [3:0] B,
  input  logic [3:0] G,
  input  logic       Cout
`ifdef ALU4_ARB_ZFLAG_EN
  ,
  output logic       ZERO0,
  output logic       ZERO1
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t state;
  logic   last;
  logic   gid;
  logic   take;
  logic   pick;

  // On contention the channel not granted last wins; a lone request always wins.
  always_comb begin
    take = REQ0 | REQ1;
    pick = (REQ0 & REQ1) ? ~last : REQ1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      last  <= 1'b1;
      gid   <= 1'b0;
      ACK0  <= 1'b0;
      ACK1  <= 1'b0;
      RDY0  <= 1'b0;
      RDY1  <= 1'b0;
      RES0  <= '0;
      RES1  <= '0;
      COUT0 <= 1'b0;
      COUT1 <= 1'b0;
      BUSY  <= 1'b0;
      {S2, S1, S0, Cin} <= '0;
      A     <= '0;
      B     <= '0;
`ifdef ALU4_ARB_ZFLAG_EN
      ZERO0 <= 1'b0;
      ZERO1 <= 1'b0;
`endif
    end else begin
      ACK0 <= 1'b0;
      ACK1 <= 1'b0;
      RDY0 <= 1'b0;
      RDY1 <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            {S2, S1, S0, Cin} <= pick ? OP1 : OP0;
            A     <= pick ? A1 : A0;
            B     <= pick ? B1 : B0;
            gid   <= pick;
            last  <= pick;
            ACK0  <= ~pick;
            ACK1  <= pick;
            BUSY  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (gid) begin
            RES1  <= G;
            COUT1 <= Cout;
`ifdef ALU4_ARB_ZFLAG_EN
            ZERO1 <= (G == 4'b0000);
`endif
          end else begin
            RES0  <= G;
            COUT0 <= Cout;
`ifdef ALU4_ARB_ZFLAG_EN
            ZERO0 <= (G == 4'b0000);
`endif
          end
          RDY0  <= ~gid;
          RDY1  <= gid;
          state <= WB;
        end
        WB: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
